alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; legal values 8..64, power of two.
REQ-002 Parameter SHW, default $clog2(WIDTH), width of shift-amount field; derived, not overridden.
REQ-003 clock  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  4  operation select, captured with start.
REQ-007 a  input  WIDTH  operand A, captured with start.
REQ-008 b  input  WIDTH  operand B; b[SHW-1:0] is the shift amount for shifts.
REQ-009 cin  input  1  carry in, captured with start.
REQ-010 busy  output  1  high from the cycle after acceptance until the result is presented.
REQ-011 done  output  1  one-cycle pulse coinciding with new y/cout/zout.
REQ-012 y  output  WIDTH  registered result, held until next done.
REQ-013 cout  output  1  registered carry/shift-out/overflow flag.
REQ-014 zout  output  1  registered, high when y == 0.

Function
REQ-015 Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL; 8..15 reserved.
REQ-016 ADD: {cout,y} = a + b + cin, WIDTH+1-bit arithmetic.
REQ-017 SUB: {cout,y} = a + ~b + cin (cout=1 means no borrow when cin=1).
REQ-018 AND/OR/XOR: y bitwise, cout = 0.
REQ-019 Reserved ops: y = a, cout = 0, single-cycle timing.
REQ-020 Single-cycle ops (0-4, reserved): accepted at edge N, done=1 and result valid after edge N+1; busy stays 0.
REQ-021 SHL/SHR: logical, zero fill, one bit per cycle, n = b[SHW-1:0]; cout = last bit shifted out (a[WIDTH-1] first for SHL, a[0] first for SHR).
REQ-022 Shift n = 0: treated as single-cycle, y = a, cout = 0.
REQ-023 Shift n > 0: done after edge N+n+1; busy high for n cycles.
REQ-024 MUL: unsigned shift-add, one multiplier bit per cycle; y = low WIDTH bits of a*b; cout = 1 iff high WIDTH bits nonzero; done after edge N+WIDTH+1.
REQ-025 FSM states: IDLE, SHIFT, MUL, FINISH; IDLE->SHIFT/MUL on start with iterative op, IDLE->FINISH on start otherwise; SHIFT/MUL->FINISH when iteration counter reaches terminal; FINISH->IDLE unconditionally, asserting done.
REQ-026 start outside IDLE is ignored; no queuing; start in FINISH cycle also ignored.
REQ-027 a, b, op, cin may change after acceptance without affecting the operation in progress.
REQ-028 y/cout/zout update only on the done cycle; otherwise hold.
REQ-029 zout computed from the final y value, never from intermediates.

Reset
REQ-030 On reset: state IDLE, busy=0, done=0, y=0, cout=0, zout=1, counters and internal registers 0.
REQ-031 Reset asserted mid-operation aborts it; no done pulse for the aborted operation.
REQ-032 Reset has priority over start in the same cycle.

Structure
REQ-033 Shared package alu_pkg holds op-code constants and the FSM state type.
REQ-034 One combinational sub-module, alu_logic, computes ops 0-4 and reserved ops; the FSM, shifter and multiplier registers live in alu_multicycle.
REQ-035 No tri-state outputs; no latches; single clock domain.

Verification (WIDTH=16)
REQ-036 ADD a=0xFFFF b=0x0001 cin=0 -> done after 1 cycle, y=0x0000, cout=1, zout=1, busy never high.
REQ-037 SHL a=0x8001 b=3 -> busy 3 cycles, done on 4th cycle, y=0x0008, cout=0; SHR a=0x0005 b=1 -> y=0x0002, cout=1.
REQ-038 MUL a=0x0100 b=0x0100 -> done 17 cycles after acceptance, y=0x0000, cout=1, zout=1; MUL 3*5 -> y=0x000F, cout=0.
REQ-039 start pulsed every cycle during MUL with different operands -> exactly one done, result of first operands only.
REQ-040 reset asserted at cycle 5 of MUL -> no done, y=0, zout=1, next ADD 2+2 yields y=0x0004 after 1 cycle.
REQ-041 SUB a=0x0003 b=0x0005 cin=1 -> y=0xFFFE, cout=0; op=0xA a=0x1234 -> y=0x1234, cout=0, single cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM state and result-select types for the multicycle ALU
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        MUL    = 2'd2,
        FINISH = 2'd3
    } aluState_t;

    // Which engine supplies the result presented on the done cycle.
    typedef enum logic [1:0] {
        SEL_LOGIC = 2'd0,
        SEL_SHIFT = 2'd1,
        SEL_MUL   = 2'd2
    } resultSel_t;

    function automatic logic isShiftOp(input logic [3:0] opCode);
        return (opCode == OP_SHL) || (opCode == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_logic.sv
// rtl/alu_logic.sv - combinational result for the single-cycle ALU operations
module alu_logic
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    logic [WIDTH:0] sum;

    // Arithmetic and bitwise ops; every other code (shift by zero, reserved) passes a through.
    always_comb begin
        sum  = '0;
        y    = a;
        cout = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                y    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
            end
            OP_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
                y    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: begin
                y    = a;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multicycle ALU with bit-serial shifter and shift-add multiplier
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zout
);

    // Counter is one bit wider than the shift field so it can hold WIDTH for MUL.
    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] MUL_COUNT = CW'(WIDTH);
    localparam logic [CW-1:0] ONE       = CW'(1);

    aluState_t  state;
    aluState_t  nextState;

    logic [3:0]       opReg;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic             cinReg;
    resultSel_t       selReg;
    logic [CW-1:0]    iterCount;

    logic [WIDTH-1:0] shiftReg;
    logic             shiftOut;
    logic [WIDTH-1:0] mulHi;
    logic [WIDTH-1:0] mulLo;
    logic [WIDTH:0]   mulSum;

    logic [SHW-1:0]   shAmt;
    logic             startShift;
    logic             startMul;
    logic             accept;
    logic             iterLast;

    logic [WIDTH-1:0] logicY;
    logic             logicCout;
    logic [WIDTH-1:0] resY;
    logic             resCout;

    assign shAmt      = b[SHW-1:0];
    assign startMul   = (op == OP_MUL);
    assign startShift = isShiftOp(op) && (shAmt != '0);
    assign iterLast   = (iterCount == ONE);

    alu_logic #(.WIDTH(WIDTH)) uLogic (
        .op   (opReg),
        .a    (aReg),
        .b    (bReg),
        .cin  (cinReg),
        .y    (logicY),
        .cout (logicCout)
    );

    // State register; reset wins over any start in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and busy/accept decode; start is only looked at in IDLE.
    always_comb begin
        nextState = state;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (startMul) begin
                        nextState = MUL;
                    end else if (startShift) begin
                        nextState = SHIFT;
                    end else begin
                        nextState = FINISH;
                    end
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (iterLast) begin
                    nextState = FINISH;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (iterLast) begin
                    nextState = FINISH;
                end
            end
            FINISH: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    always_comb begin
        mulSum = {1'b0, mulHi};
        if (mulLo[0]) begin
            mulSum = {1'b0, mulHi} + {1'b0, aReg};
        end
    end

    // Final result mux, evaluated from the completed engine state in FINISH.
    always_comb begin
        resY    = logicY;
        resCout = logicCout;
        case (selReg)
            SEL_SHIFT: begin
                resY    = shiftReg;
                resCout = shiftOut;
            end
            SEL_MUL: begin
                resY    = mulLo;
                resCout = |mulHi;
            end
            default: begin
                resY    = logicY;
                resCout = logicCout;
            end
        endcase
    end

    // Operand capture, iteration engines and the registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            opReg     <= '0;
            aReg      <= '0;
            bReg      <= '0;
            cinReg    <= 1'b0;
            selReg    <= SEL_LOGIC;
            iterCount <= '0;
            shiftReg  <= '0;
            shiftOut  <= 1'b0;
            mulHi     <= '0;
            mulLo     <= '0;
            done      <= 1'b0;
            y         <= '0;
            cout      <= 1'b0;
            zout      <= 1'b1;
        end else begin
            done <= 1'b0;
            if (accept) begin
                opReg    <= op;
                aReg     <= a;
                bReg     <= b;
                cinReg   <= cin;
                shiftReg <= a;
                shiftOut <= 1'b0;
                mulHi    <= '0;
                mulLo    <= b;
                if (startMul) begin
                    selReg    <= SEL_MUL;
                    iterCount <= MUL_COUNT;
                end else if (startShift) begin
                    selReg    <= SEL_SHIFT;
                    iterCount <= {1'b0, shAmt};
                end else begin
                    selReg    <= SEL_LOGIC;
                    iterCount <= '0;
                end
            end else if (state == SHIFT) begin
                if (opReg == OP_SHL) begin
                    shiftOut <= shiftReg[WIDTH-1];
                    shiftReg <= {shiftReg[WIDTH-2:0], 1'b0};
                end else begin
                    shiftOut <= shiftReg[0];
                    shiftReg <= {1'b0, shiftReg[WIDTH-1:1]};
                end
                iterCount <= iterCount - ONE;
            end else if (state == MUL) begin
                mulHi     <= mulSum[WIDTH:1];
                mulLo     <= {mulSum[0], mulLo[WIDTH-1:1]};
                iterCount <= iterCount - ONE;
            end else if (state == FINISH) begin
                y    <= resY;
                cout <= resCout;
                zout <= (resY == '0);
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle with a behavioural reference model
module tb_alu_multicycle;

    localparam int W = 16;

    logic          clock;
    logic          reset;
    logic          start;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  y;
    logic          cout;
    logic          zout;

    int checks   = 0;
    int failures = 0;

    alu_multicycle #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .cout  (cout),
        .zout  (zout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: result, flag and cycles from acceptance edge to done edge.
    function automatic void modelOp(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                    input logic c, output logic [W-1:0] ry, output logic rc, output int lat);
        logic [W:0]     s;
        logic [2*W-1:0] p;
        int             n;
        n   = int'(bv[3:0]);
        ry  = av;
        rc  = 1'b0;
        lat = 1;
        case (o)
            4'd0: begin s = {1'b0, av} + {1'b0, bv} + (W+1)'(c);  ry = s[W-1:0]; rc = s[W]; end
            4'd1: begin s = {1'b0, av} + {1'b0, ~bv} + (W+1)'(c); ry = s[W-1:0]; rc = s[W]; end
            4'd2: ry = av & bv;
            4'd3: ry = av | bv;
            4'd4: ry = av ^ bv;
            4'd5: if (n != 0) begin ry = av << n; rc = av[W-n]; lat = n + 1; end
            4'd6: if (n != 0) begin ry = av >> n; rc = av[n-1]; lat = n + 1; end
            4'd7: begin p = av * bv; ry = p[W-1:0]; rc = (p[2*W-1:W] != 0); lat = W + 1; end
            default: ry = av;
        endcase
    endfunction

    int           cyc = 0;
    logic         pending = 1'b0;
    int           accCyc = 0;
    int           expLat = 1;
    logic [W-1:0] pendY = '0;
    logic         pendC = 1'b0;
    logic [W-1:0] heldY = '0;
    logic         heldC = 1'b0;

    // Per-cycle compare: inputs seen here are the ones sampled at the edge just passed.
    always @(negedge clock) begin
        logic expDone;
        logic expBusy;
        cyc++;
        expDone = 1'b0;
        if (reset) begin
            pending = 1'b0;
            heldY   = '0;
            heldC   = 1'b0;
        end else if (pending && cyc == accCyc + expLat) begin
            expDone = 1'b1;
            heldY   = pendY;
            heldC   = pendC;
            pending = 1'b0;
        end else if (!pending && start) begin
            pending = 1'b1;
            accCyc  = cyc;
            modelOp(op, a, b, cin, pendY, pendC, expLat);
        end
        expBusy = pending && (expLat > 1) && (cyc < accCyc + expLat - 1);
        check("cyc_done", 32'(done), 32'(expDone));
        check("cyc_busy", 32'(busy), 32'(expBusy));
        check("cyc_y",    32'(y),    32'(heldY));
        check("cyc_cout", 32'(cout), 32'(heldC));
        check("cyc_zout", 32'(zout), 32'(heldY == '0));
    end

    // Issue one op, scramble inputs after acceptance, then pin the result to literals.
    task automatic runOp(input string name, input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic c, input logic [W-1:0] ey, input logic ec, input logic ez, input int elat);
        int n;
        @(negedge clock); #1;
        start = 1'b1; op = o; a = av; b = bv; cin = c;
        @(negedge clock); #1;
        start = 1'b0;
        op = 4'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clock);
            n++;
        end
        check({name, "_lat"},  32'(n),    32'(elat));
        check({name, "_y"},    32'(y),    32'(ey));
        check({name, "_cout"}, 32'(cout), 32'(ec));
        check({name, "_zout"}, 32'(zout), 32'(ez));
    endtask

    initial begin
        int n;
        int doneSeen;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_y",    32'(y),    32'h0);
        check("reset_zout", 32'(zout), 32'h1);
        check("reset_busy", 32'(busy), 32'h0);
        #1 reset = 1'b0;

        runOp("add_wrap", 4'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1);
        runOp("add_cin",  4'd0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1);
        runOp("sub",      4'd1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1);
        runOp("and",      4'd2, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0, 1'b0, 1);
        runOp("or",       4'd3, 16'hF0F0, 16'h3C3C, 1'b0, 16'hFCFC, 1'b0, 1'b0, 1);
        runOp("xor",      4'd4, 16'hF0F0, 16'h3C3C, 1'b0, 16'hCCCC, 1'b0, 1'b0, 1);
        runOp("xor_zero", 4'd4, 16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b1, 1);
        runOp("shl3",     4'd5, 16'h8001, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 4);
        runOp("shr1",     4'd6, 16'h0005, 16'h0001, 1'b0, 16'h0002, 1'b1, 1'b0, 2);
        runOp("shl0",     4'd5, 16'h00AB, 16'h0010, 1'b0, 16'h00AB, 1'b0, 1'b0, 1);
        runOp("shr15",    4'd6, 16'hC000, 16'h000F, 1'b0, 16'h0001, 1'b1, 1'b0, 16);
        runOp("mul_ovf",  4'd7, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, 1'b1, 17);
        runOp("mul_3x5",  4'd7, 16'h0003, 16'h0005, 1'b0, 16'h000F, 1'b0, 1'b0, 17);
        runOp("reserved", 4'hA, 16'h1234, 16'h5555, 1'b1, 16'h1234, 1'b0, 1'b0, 1);

        // start held high with fresh operands every cycle of a MUL
        @(negedge clock); #1;
        start = 1'b1; op = 4'd7; a = 16'h1234; b = 16'h0003; cin = 1'b0;
        n = 0;
        @(negedge clock);
        while (!done && n < 100) begin
            #1;
            op = 4'($urandom_range(0, 15)); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(negedge clock);
            n++;
        end
        #1 start = 1'b0;
        check("mulstorm_lat", 32'(n), 32'd17);
        check("mulstorm_y",   32'(y), 32'h369C);
        check("mulstorm_cout", 32'(cout), 32'h0);
        doneSeen = 0;
        repeat (20) begin
            @(negedge clock);
            if (done) doneSeen++;
        end
        check("mulstorm_extra_done", 32'(doneSeen), 32'h0);

        // reset partway through a MUL
        @(negedge clock); #1;
        start = 1'b1; op = 4'd7; a = 16'h0003; b = 16'h0005;
        @(negedge clock); #1;
        start = 1'b0;
        repeat (4) @(negedge clock);
        #1 reset = 1'b1;
        @(negedge clock); #1;
        reset = 1'b0;
        doneSeen = 0;
        repeat (25) begin
            @(negedge clock);
            if (done) doneSeen++;
        end
        check("abort_no_done", 32'(doneSeen), 32'h0);
        check("abort_y",       32'(y),        32'h0);
        check("abort_zout",    32'(zout),     32'h1);
        runOp("add_after_abort", 4'd0, 16'h0002, 16'h0002, 1'b0, 16'h0004, 1'b0, 1'b0, 1);

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
